uart_boot_ctrl: RTL and testbench

UART_BOOT_CTRL -- requirements
Module: uart_boot_ctrl

---
 rtl/uart_boot_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_uart_boot_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_boot_ctrl.sv
// UART image loader: received bytes are packed into words and written to RAM at boot,
// then a scan_memory edge reads the RAM back out over tx word by word.
module uart_boot_ctrl #(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ce,
    input  logic              rx,
    output logic              tx,
    input  logic              scan_memory,
    output logic              boot,
    input  logic [DATA_W-1:0] ram_out,
    output logic [DATA_W-1:0] ram_in,
    output logic [ADDR_W-1:0] ram_adr,
    output logic              ram_rw,
    output logic              ram_enable,
    output logic              frame_err
);
    localparam int BYTES = DATA_W / 8;
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BC_W-1:0]  LAST_BYTE = BC_W'(BYTES - 1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [2:0] {BOOT, IDLE, SCAN_RD, SCAN_WAIT, SCAN_TX} state_t;

    rx_state_t         rx_state;
    logic              rx_meta, rx_sync, rx_last;
    logic [CNT_W-1:0]  rx_cnt;
    logic [2:0]        rx_bits;
    logic [7:0]        rx_shift;
    logic              rx_vld;

    state_t            state;
    logic [ADDR_W-1:0] index;
    logic [DATA_W-1:0] acc, acc_next;
    logic [BC_W-1:0]   bcnt;
    logic              scan_prev;
    logic [DATA_W-1:0] tx_word;
    logic [CNT_W-1:0]  tx_cnt;
    logic [3:0]        tx_bit;
    logic [BC_W-1:0]   tx_byte;

    // New byte enters at the top so the first byte ends up in the low lane.
    assign acc_next = (acc >> 8) | (DATA_W'(rx_shift) << (DATA_W - 8));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_last   <= 1'b1;
            rx_state  <= R_IDLE;
            rx_cnt    <= '0;
            rx_bits   <= '0;
            rx_shift  <= '0;
            rx_vld    <= 1'b0;
            frame_err <= 1'b0;
        end else if (ce) begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_last <= rx_sync;
            rx_vld  <= 1'b0;
            case (rx_state)
                R_IDLE: begin
                    if (rx_last && !rx_sync) begin
                        rx_state <= R_START;
                        rx_cnt   <= '0;
                    end
                end
                R_START: begin
                    if (rx_cnt == HALF_M1) begin
                        rx_cnt   <= '0;
                        rx_bits  <= '0;
                        rx_state <= rx_sync ? R_IDLE : R_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                R_DATA: begin
                    if (rx_cnt == LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        rx_bits  <= rx_bits + 1'b1;
                        if (rx_bits == 3'd7) rx_state <= R_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                R_STOP: begin
                    if (rx_cnt == LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= R_IDLE;
                        if (rx_sync) rx_vld    <= 1'b1;
                        else         frame_err <= 1'b1;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_state <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= BOOT;
            boot       <= 1'b1;
            tx         <= 1'b1;
            ram_enable <= 1'b0;
            ram_rw     <= 1'b0;
            ram_adr    <= '0;
            ram_in     <= '0;
            index      <= '0;
            acc        <= '0;
            bcnt       <= '0;
            scan_prev  <= 1'b0;
            tx_word    <= '0;
            tx_cnt     <= '0;
            tx_bit     <= '0;
            tx_byte    <= '0;
        end else if (ce) begin
            scan_prev  <= scan_memory;
            ram_enable <= 1'b0;
            ram_rw     <= 1'b0;
            case (state)
                BOOT: begin
                    // Leave one cycle after the final write is on the bus.
                    if (ram_enable && ram_rw && ram_adr == '1) begin
                        state <= IDLE;
                        boot  <= 1'b0;
                    end
                    if (rx_vld) begin
                        if (bcnt == LAST_BYTE) begin
                            bcnt       <= '0;
                            ram_enable <= 1'b1;
                            ram_rw     <= 1'b1;
                            ram_adr    <= index;
                            ram_in     <= acc_next;
                            index      <= index + 1'b1;
                        end else begin
                            bcnt <= bcnt + 1'b1;
                            acc  <= acc_next;
                        end
                    end
                end
                IDLE: begin
                    if (scan_memory && !scan_prev) begin
                        state      <= SCAN_RD;
                        ram_enable <= 1'b1;
                        ram_adr    <= index;
                    end
                end
                SCAN_RD: state <= SCAN_WAIT;
                SCAN_WAIT: begin
                    tx_word <= ram_out;
                    tx      <= 1'b0;
                    tx_cnt  <= '0;
                    tx_bit  <= '0;
                    tx_byte <= '0;
                    state   <= SCAN_TX;
                end
                SCAN_TX: begin
                    if (tx_cnt == LAST) begin
                        tx_cnt <= '0;
                        if (tx_bit == 4'd9) begin
                            if (tx_byte == LAST_BYTE) begin
                                tx <= 1'b1;
                                if (index == '1) begin
                                    index <= '0;
                                    state <= IDLE;
                                end else begin
                                    index      <= index + 1'b1;
                                    ram_adr    <= index + 1'b1;
                                    ram_enable <= 1'b1;
                                    state      <= SCAN_RD;
                                end
                            end else begin
                                tx_byte <= tx_byte + 1'b1;
                                tx_bit  <= '0;
                                tx      <= 1'b0;
                                tx_word <= tx_word >> 8;
                            end
                        end else begin
                            tx_bit <= tx_bit + 1'b1;
                            tx     <= (tx_bit == 4'd8) ? 1'b1 : tx_word[tx_bit[2:0]];
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_boot_ctrl.sv
// Bench for uart_boot_ctrl: UART load, frame errors, reset abort and RAM scan-out with ce stalls.
module tb_uart_boot_ctrl;
    localparam int CPB = 4;
    localparam int AW  = 2;
    localparam int DW  = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ce = 1'b0;
    logic          rx = 1'b1;
    logic          scan_memory = 1'b0;
    logic [DW-1:0] ram_out = '0;
    logic          tx, boot, ram_rw, ram_enable, frame_err;
    logic [DW-1:0] ram_in;
    logic [AW-1:0] ram_adr;

    int checks = 0;
    int errors = 0;

    uart_boot_ctrl #(.CLKS_PER_BIT(CPB), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .rx(rx), .tx(tx),
        .scan_memory(scan_memory), .boot(boot), .ram_out(ram_out),
        .ram_in(ram_in), .ram_adr(ram_adr), .ram_rw(ram_rw),
        .ram_enable(ram_enable), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // RAM model and bus logging
    logic [DW-1:0] mem [4];
    logic [AW-1:0] wr_adr_q[$];
    logic [DW-1:0] wr_dat_q[$];
    logic [AW-1:0] rd_adr_q[$];
    int cyc = 0, last_wr_cyc = -100, boot_fall_cyc = -100, rw_viol = 0;
    logic boot_prev = 1'b0;
    bit edge_act = 1'b0;

    always @(posedge clk) begin
        cyc++;
        edge_act = ce;
        if (ram_enable && ce) begin
            if (ram_rw) begin
                mem[ram_adr] <= ram_in;
                wr_adr_q.push_back(ram_adr);
                wr_dat_q.push_back(ram_in);
                last_wr_cyc = cyc;
            end else begin
                ram_out <= mem[ram_adr];
                rd_adr_q.push_back(ram_adr);
            end
        end
        if (!ram_enable && ram_rw) rw_viol++;
        if (boot_prev && !boot) boot_fall_cyc = cyc;
        boot_prev = boot;
    end

    // UART decoder on tx, counting only clock-enabled cycles
    logic [7:0] byte_q[$];
    int start_q[$];
    int ecyc = 0, dec_p = 0, dec_bad = 0;
    bit dec_busy = 1'b0;
    logic [7:0] dec_sh;

    always @(negedge clk) begin
        if (edge_act && rst_n) begin
            ecyc++;
            if (!dec_busy) begin
                if (tx == 1'b0) begin
                    dec_busy = 1'b1;
                    dec_p = 0;
                    start_q.push_back(ecyc);
                end
            end else begin
                dec_p++;
            end
            if (dec_busy && (dec_p % CPB) == CPB / 2) begin
                if (dec_p / CPB == 0) begin
                    if (tx !== 1'b0) dec_bad++;
                end else if (dec_p / CPB <= 8) begin
                    dec_sh[dec_p / CPB - 1] = tx;
                end else begin
                    if (tx !== 1'b1) dec_bad++;
                    byte_q.push_back(dec_sh);
                    dec_busy = 1'b0;
                end
            end
        end
    end

    logic [DW-1:0] exp_mem [4];

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_b);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = stop_b;
        tick(CPB);
        rx = 1'b1;
    endtask

    task automatic clear_logs;
        wr_adr_q.delete();
        wr_dat_q.delete();
        rd_adr_q.delete();
        byte_q.delete();
        start_q.delete();
        dec_bad = 0;
        rw_viol = 0;
    endtask

    task automatic check_reset_values(input string tag);
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL %s tx got %b want 1", tag, tx); end
        checks++; if (boot !== 1'b1) begin errors++; $display("FAIL %s boot got %b want 1", tag, boot); end
        checks++; if (ram_enable !== 1'b0) begin errors++; $display("FAIL %s ram_enable got %b want 0", tag, ram_enable); end
        checks++; if (ram_rw !== 1'b0) begin errors++; $display("FAIL %s ram_rw got %b want 0", tag, ram_rw); end
        checks++; if (ram_adr !== '0) begin errors++; $display("FAIL %s ram_adr got %h want 0", tag, ram_adr); end
        checks++; if (ram_in !== '0) begin errors++; $display("FAIL %s ram_in got %h want 0", tag, ram_in); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL %s frame_err got %b want 0", tag, frame_err); end
    endtask

    task automatic load_image(input logic [7:0] img [8], input string tag);
        boot_fall_cyc = -100;
        for (int k = 0; k < 4; k++) exp_mem[k] = {img[2*k+1], img[2*k]};
        for (int i = 0; i < 6; i++) send_byte(img[i], 1'b1);
        tick(5);
        checks++; if (boot !== 1'b1 || wr_adr_q.size() != 3) begin
            errors++; $display("FAIL %s_midload boot=%b writes=%0d want boot=1 writes=3", tag, boot, wr_adr_q.size());
        end
        for (int i = 6; i < 8; i++) send_byte(img[i], 1'b1);
        tick(10);
        checks++; if (wr_adr_q.size() != 4) begin
            errors++; $display("FAIL %s_wr_count got %0d want 4", tag, wr_adr_q.size());
        end
        for (int k = 0; k < 4 && k < wr_adr_q.size(); k++) begin
            checks++; if (wr_adr_q[k] !== AW'(k) || wr_dat_q[k] !== exp_mem[k]) begin
                errors++; $display("FAIL %s_write%0d got adr=%0d data=%h want adr=%0d data=%h",
                                   tag, k, wr_adr_q[k], wr_dat_q[k], k, exp_mem[k]);
            end
        end
        checks++; if (boot !== 1'b0 || boot_fall_cyc - last_wr_cyc != 1) begin
            errors++; $display("FAIL %s_boot_fall boot=%b fall-write=%0d want boot=0 delta=1",
                               tag, boot, boot_fall_cyc - last_wr_cyc);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        ce = 1'b0;
        tick(3);
        check_reset_values("reset");
        rst_n = 1'b1;
        ce = 1'b1;
        tick(4);
        clear_logs();
    endtask

    task automatic test_frame_err;
        send_byte(8'h55, 1'b0);
        tick(20);
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL frame_err got %b want 1", frame_err); end
        checks++; if (wr_adr_q.size() != 0) begin errors++; $display("FAIL frame_err_nowrite writes=%0d want 0", wr_adr_q.size()); end
    endtask

    task automatic test_glitch;
        rx = 1'b0;
        tick(1);
        rx = 1'b1;
        tick(60);
        checks++; if (wr_adr_q.size() != 0 || frame_err !== 1'b1) begin
            errors++; $display("FAIL glitch writes=%0d frame_err=%b want 0 and 1", wr_adr_q.size(), frame_err);
        end
    endtask

    task automatic test_load_fixed;
        logic [7:0] img [8];
        img = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A, 8'hF0, 8'hDE};
        // A scan request while booting must be dropped.
        scan_memory = 1'b1;
        tick(3);
        scan_memory = 1'b0;
        load_image(img, "load_fixed");
    endtask

    task automatic test_idle_ignore;
        send_byte(8'($urandom_range(0, 255)), 1'b1);
        send_byte(8'($urandom_range(0, 255)), 1'b1);
        tick(20);
        checks++; if (wr_adr_q.size() != 4 || byte_q.size() != 0) begin
            errors++; $display("FAIL idle_ignore writes=%0d tx_bytes=%0d want 4 and 0", wr_adr_q.size(), byte_q.size());
        end
    endtask

    task automatic run_scan(input bit freeze, input string tag);
        int n;
        logic held;
        int frozen_bad;
        clear_logs();
        scan_memory = 1'b1;
        tick(3);
        scan_memory = 1'b0;
        if (freeze) begin
            n = 0;
            while (byte_q.size() < 1 && n < 500) begin tick(1); n++; end
            tick(7);
            held = tx;
            frozen_bad = 0;
            ce = 1'b0;
            for (int i = 0; i < 10; i++) begin
                tick(1);
                if (tx !== held) frozen_bad++;
            end
            ce = 1'b1;
            checks++; if (frozen_bad != 0) begin
                errors++; $display("FAIL %s_freeze tx moved %0d times want 0", tag, frozen_bad);
            end
        end else begin
            tick(100);
            scan_memory = 1'b1;
            tick(3);
            scan_memory = 1'b0;
        end
        n = 0;
        while (byte_q.size() < 8 && n < 3000) begin tick(1); n++; end
        checks++; if (byte_q.size() < 8) begin
            errors++; $display("FAIL %s_timeout tx bytes got %0d want 8", tag, byte_q.size());
        end
        for (int i = 0; i < 8 && i < byte_q.size(); i++) begin
            logic [DW-1:0] w;
            logic [7:0] eb;
            w = exp_mem[i / 2];
            eb = (i % 2 == 0) ? w[7:0] : w[15:8];
            checks++; if (byte_q[i] !== eb) begin
                errors++; $display("FAIL %s_byte%0d got %h want %h", tag, i, byte_q[i], eb);
            end
        end
        for (int k = 0; k + 1 < start_q.size() && k < 8; k += 2) begin
            checks++; if (start_q[k+1] - start_q[k] != 10 * CPB) begin
                errors++; $display("FAIL %s_spacing%0d got %0d want %0d", tag, k, start_q[k+1] - start_q[k], 10 * CPB);
            end
        end
        tick(200);
        checks++; if (tx !== 1'b1 || byte_q.size() != 8 || dec_bad != 0) begin
            errors++; $display("FAIL %s_idle tx=%b bytes=%0d framing_errs=%0d want 1, 8, 0", tag, tx, byte_q.size(), dec_bad);
        end
        checks++; if (rd_adr_q.size() != 4 || wr_adr_q.size() != 0 || rw_viol != 0) begin
            errors++; $display("FAIL %s_bus reads=%0d writes=%0d rw_viol=%0d want 4, 0, 0", tag, rd_adr_q.size(), wr_adr_q.size(), rw_viol);
        end
        for (int k = 0; k < 4 && k < rd_adr_q.size(); k++) begin
            checks++; if (rd_adr_q[k] !== AW'(k)) begin
                errors++; $display("FAIL %s_rdadr%0d got %0d want %0d", tag, k, rd_adr_q[k], k);
            end
        end
    endtask

    task automatic test_reset_midload;
        logic [7:0] img [8];
        for (int i = 0; i < 3; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
        rx = 1'b0;
        tick(3 * CPB);
        rst_n = 1'b0;
        tick(2);
        rx = 1'b1;
        check_reset_values("midload_reset");
        rst_n = 1'b1;
        tick(5);
        clear_logs();
        for (int i = 0; i < 8; i++) img[i] = 8'($urandom_range(0, 255));
        load_image(img, "reload");
    endtask

    initial begin
        test_reset();
        test_frame_err();
        test_glitch();
        test_load_fixed();
        test_idle_ignore();
        run_scan(1'b0, "scan");
        test_reset_midload();
        run_scan(1'b1, "scan_ce");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
